bsg_manycore_endpoint_mem_responder: RTL and testbench
======================================================

Name: bsg_manycore_endpoint_mem_responder

Overview:
Memory-mapped responder that sits on a router P port in place of a compute socket, at the far end of the forward/reverse request protocol that vanilla-core tiles initiate. It accepts forward request packets (load, store, atomic add), executes them against a local synchronous scratchpad, and returns one reverse response packet per request to the requester's coordinates. The forward side is credit-safe: a request is consumed only when response buffering for it is already guaranteed.

Parameters:
data_width_p, 32, data word width; byte mask width is data_width_p/8
addr_width_p, 28, word address width of incoming requests
x_cord_width_p, 7, X coordinate width
y_cord_width_p, 7, Y coordinate width
mem_els_p, 1024, scratchpad depth in words (power of 2, at least 2); index width lg_els = clog2(mem_els_p)
rev_fifo_els_p, 2, response FIFO depth (at least 2)
reg_id_width_p, 5, request tag width echoed in the response

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
fwd_v_i  in  1  forward request valid
fwd_op_i  in  2  0=load, 1=store, 2=amoadd, 3=illegal
fwd_addr_i  in  addr_width_p  word address
fwd_data_i  in  data_width_p  store/amo operand
fwd_mask_i  in  data_width_p/8  store byte mask (ignored for amoadd and load)
fwd_src_x_i  in  x_cord_width_p  requester X
fwd_src_y_i  in  y_cord_width_p  requester Y
fwd_reg_id_i  in  reg_id_width_p  request tag
fwd_yumi_o  out  1  request consumed this cycle
rev_v_o  out  1  response valid (FIFO head)
rev_type_o  out  2  0=load data, 1=write ack, 2=amo data, 3=error
rev_data_o  out  data_width_p  response data
rev_dest_x_o  out  x_cord_width_p  = request src X
rev_dest_y_o  out  y_cord_width_p  = request src Y
rev_reg_id_o  out  reg_id_width_p  echoed tag
rev_ready_i  in  1  downstream accepts head when rev_v_o & rev_ready_i

Behaviour:
- Reset: fwd_yumi_o=0, rev_v_o=0, FIFO empty, in-flight stage empty, FSM=IDLE, response credit count = rev_fifo_els_p. Scratchpad contents are not cleared.
- Index is fwd_addr_i[lg_els-1:0]; upper address bits are ignored, so the address wraps modulo mem_els_p.
- Credits: credits = rev_fifo_els_p - (FIFO occupancy + in-flight response). fwd_yumi_o = fwd_v_i & FSM==IDLE & credits>0. fwd_yumi_o is combinational from fwd_v_i.
- The FIFO dequeue in a cycle returns its credit in that same cycle. A dequeue and an accept in the same cycle are legal when credits==0 before the dequeue.
- FSM states are IDLE and AMO_WB.
- Load: accept in cycle T, SRAM read in T, data enqueued at the end of T+1, rev_v_o visible at T+2 at the earliest. Type 0.
- Store: byte-masked write in accept cycle T. Ack (type 1, data 0) enqueued at the end of T+1.
- Amoadd: accept in T with a read. IDLE goes to AMO_WB. In T+1, write old+fwd_data (mod 2^data_width_p), enqueue old value as type 2, and no accept. AMO_WB goes to IDLE.
- Illegal op: consumed, no memory access. Type 3 response with data 0, enqueued at T+1.
- Read-after-write: a load accepted the cycle after a store or amo writeback to the same index returns the new value. The SRAM is write-first, or a bypass is used.
- FIFO ordering is strictly in request-acceptance order. rev_* outputs come from the FIFO head and are stable while rev_v_o & ~rev_ready_i.
- Full FIFO: fwd_yumi_o stays 0 until credits>0. Requests are never dropped.
- Reset mid-operation: the in-flight response and FIFO contents are discarded. A partially completed amoadd does not write back.
- X or Z on fwd_* while fwd_v_i=0 must not affect state.

Test Plan:
- Reset then idle: fwd_v_i=0 for 10 cycles -> rev_v_o=0, fwd_yumi_o=0 throughout.
- Store 0xA5A5A5A5 mask 4'b1111 to addr 3, then load addr 3 with reg_id 7 from (x=2, y=5) -> ack type1 then type0 data 0xA5A5A5A5, dest (2,5), reg_id 7; the load response appears 2 cycles after its accept.
- Masked store 0x11223344 mask 4'b0101 over 0xFFFFFFFF at addr 8, then load -> 0xFF22FF44.
- Amoadd 5 to addr 10 holding 0xFFFFFFFE, then load addr 10 -> type2 data 0xFFFFFFFE, then type0 data 3. fwd_yumi_o is low in the cycle after the amo accept.
- Backpressure: rev_ready_i=0 with 4 back-to-back loads, rev_fifo_els_p=2 -> exactly 2 accepted, then fwd_yumi_o=0. Releasing rev_ready_i drains the responses in order and the remaining 2 loads are accepted one per freed credit.
- Wrap and illegal: load addr mem_els_p+3 -> same data as addr 3. op=3 -> type3 response with data 0 and the memory is unchanged.

Source files
------------

// File: rtl/bsg_manycore_endpoint_mem_responder.sv
// Memory-mapped endpoint that serves forward load/store/amoadd requests against a
// local synchronous scratchpad and returns one reverse response per request, in
// acceptance order. A request is only consumed once response buffering is reserved.
module bsg_manycore_endpoint_mem_responder #(
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned addr_width_p   = 28,
  parameter int unsigned x_cord_width_p = 7,
  parameter int unsigned y_cord_width_p = 7,
  parameter int unsigned mem_els_p      = 1024,
  parameter int unsigned rev_fifo_els_p = 2,
  parameter int unsigned reg_id_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        fwd_v_i,
  input  logic [1:0]                  fwd_op_i,
  input  logic [addr_width_p-1:0]     fwd_addr_i,
  input  logic [data_width_p-1:0]     fwd_data_i,
  input  logic [data_width_p/8-1:0]   fwd_mask_i,
  input  logic [x_cord_width_p-1:0]   fwd_src_x_i,
  input  logic [y_cord_width_p-1:0]   fwd_src_y_i,
  input  logic [reg_id_width_p-1:0]   fwd_reg_id_i,
  output logic                        fwd_yumi_o,

  output logic                        rev_v_o,
  output logic [1:0]                  rev_type_o,
  output logic [data_width_p-1:0]     rev_data_o,
  output logic [x_cord_width_p-1:0]   rev_dest_x_o,
  output logic [y_cord_width_p-1:0]   rev_dest_y_o,
  output logic [reg_id_width_p-1:0]   rev_reg_id_o,
  input  logic                        rev_ready_i
);

  localparam int unsigned LgEls     = $clog2(mem_els_p);
  localparam int unsigned MaskWidth = data_width_p / 8;
  localparam int unsigned PtrWidth  = (rev_fifo_els_p > 1) ? $clog2(rev_fifo_els_p) : 1;
  localparam int unsigned CntWidth  = $clog2(rev_fifo_els_p + 2);

  // Response type encoding coincides with the request opcode encoding.
  localparam logic [1:0] OpLoad    = 2'd0;
  localparam logic [1:0] OpStore   = 2'd1;
  localparam logic [1:0] OpAmoAdd  = 2'd2;

  typedef enum logic [0:0] {StIdle, StAmoWb} state_e;

  state_e                     state_q;
  logic                       accept;
  logic                       credit_avail;
  logic [LgEls-1:0]           idx;
  logic [CntWidth-1:0]        used;

  // Scratchpad and its single write port
  logic [data_width_p-1:0]    mem [mem_els_p];
  logic                       mem_we;
  logic [LgEls-1:0]           mem_waddr;
  logic [data_width_p-1:0]    mem_wdata;
  logic [MaskWidth-1:0]       mem_wmask;
  logic [data_width_p-1:0]    rd_data_q;

  // In-flight stage: request accepted last cycle, response enqueued this cycle
  logic                       infl_v_q;
  logic [1:0]                 infl_op_q;
  logic [x_cord_width_p-1:0]  infl_x_q;
  logic [y_cord_width_p-1:0]  infl_y_q;
  logic [reg_id_width_p-1:0]  infl_id_q;
  logic [LgEls-1:0]           amo_idx_q;
  logic [data_width_p-1:0]    amo_operand_q;

  // Response FIFO
  logic [1:0]                 fifo_type [rev_fifo_els_p];
  logic [data_width_p-1:0]    fifo_data [rev_fifo_els_p];
  logic [x_cord_width_p-1:0]  fifo_x    [rev_fifo_els_p];
  logic [y_cord_width_p-1:0]  fifo_y    [rev_fifo_els_p];
  logic [reg_id_width_p-1:0]  fifo_id   [rev_fifo_els_p];
  logic [PtrWidth-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]        count_q;
  logic                       enq, deq;
  logic [data_width_p-1:0]    enq_data;

  // Upper address bits are deliberately ignored: the index wraps modulo mem_els_p.
  logic unused_addr;
  assign unused_addr = ^fwd_addr_i[addr_width_p-1:LgEls];

  assign idx = fwd_addr_i[LgEls-1:0];

  assign enq     = infl_v_q;
  assign deq     = rev_v_o & rev_ready_i;
  assign rev_v_o = (count_q != '0);

  // A dequeue frees its slot in the same cycle, so it counts as an available credit.
  assign used         = count_q + CntWidth'(infl_v_q);
  assign credit_avail = (used < CntWidth'(rev_fifo_els_p)) | deq;

  assign accept     = fwd_v_i & ~reset_i & (state_q == StIdle) & credit_avail;
  assign fwd_yumi_o = accept;

  // Write-port mux: amo writeback owns the port in StAmoWb, otherwise stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = fwd_data_i;
    mem_wmask = fwd_mask_i;
    if (state_q == StAmoWb) begin
      mem_we    = 1'b1;
      mem_waddr = amo_idx_q;
      mem_wdata = rd_data_q + amo_operand_q;
      mem_wmask = '1;
    end else if (accept && (fwd_op_i == OpStore)) begin
      mem_we = 1'b1;
    end
    // A reset in the middle of an amoadd must drop its writeback.
    if (reset_i) mem_we = 1'b0;
  end

  // Byte-masked scratchpad write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < MaskWidth; b++) begin
        if (mem_wmask[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Synchronous read for loads and amo old-value fetch.
  always_ff @(posedge clk_i) begin
    if (accept && ((fwd_op_i == OpLoad) || (fwd_op_i == OpAmoAdd))) begin
      rd_data_q <= mem[idx];
    end
  end

  // Control FSM and in-flight valid; amoadd blocks acceptance for its writeback cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      infl_v_q <= 1'b0;
    end else begin
      infl_v_q <= accept;
      unique case (state_q)
        StIdle:  if (accept && (fwd_op_i == OpAmoAdd)) state_q <= StAmoWb;
        StAmoWb: state_q <= StIdle;
      endcase
    end
  end

  // Capture request fields needed to build the response and the amo writeback.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      infl_op_q     <= fwd_op_i;
      infl_x_q      <= fwd_src_x_i;
      infl_y_q      <= fwd_src_y_i;
      infl_id_q     <= fwd_reg_id_i;
      amo_idx_q     <= idx;
      amo_operand_q <= fwd_data_i;
    end
  end

  // Loads and amoadds return read data; store acks and errors return zero.
  always_comb begin
    enq_data = '0;
    if ((infl_op_q == OpLoad) || (infl_op_q == OpAmoAdd)) enq_data = rd_data_q;
  end

  // FIFO storage; credits guarantee an enqueue never finds it full.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_type[wr_ptr_q] <= infl_op_q;
      fifo_data[wr_ptr_q] <= enq_data;
      fifo_x[wr_ptr_q]    <= infl_x_q;
      fifo_y[wr_ptr_q]    <= infl_y_q;
      fifo_id[wr_ptr_q]   <= infl_id_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(rev_fifo_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(rev_fifo_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rev_type_o   = fifo_type[rd_ptr_q];
  assign rev_data_o   = fifo_data[rd_ptr_q];
  assign rev_dest_x_o = fifo_x[rd_ptr_q];
  assign rev_dest_y_o = fifo_y[rd_ptr_q];
  assign rev_reg_id_o = fifo_id[rd_ptr_q];

endmodule

// File: tb/tb_bsg_manycore_endpoint_mem_responder.sv
// Randomized and directed bench for the memory endpoint responder, checked against
// a word-array memory model and a queue of expected responses in acceptance order.
module tb_bsg_manycore_endpoint_mem_responder;

  localparam int unsigned Els = 1024;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fwd_v_i;
  logic [1:0]  fwd_op_i;
  logic [27:0] fwd_addr_i;
  logic [31:0] fwd_data_i;
  logic [3:0]  fwd_mask_i;
  logic [6:0]  fwd_src_x_i;
  logic [6:0]  fwd_src_y_i;
  logic [4:0]  fwd_reg_id_i;
  logic        fwd_yumi_o;
  logic        rev_v_o;
  logic [1:0]  rev_type_o;
  logic [31:0] rev_data_o;
  logic [6:0]  rev_dest_x_o;
  logic [6:0]  rev_dest_y_o;
  logic [4:0]  rev_reg_id_o;
  logic        rev_ready_i;

  bsg_manycore_endpoint_mem_responder dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .fwd_v_i      (fwd_v_i),
    .fwd_op_i     (fwd_op_i),
    .fwd_addr_i   (fwd_addr_i),
    .fwd_data_i   (fwd_data_i),
    .fwd_mask_i   (fwd_mask_i),
    .fwd_src_x_i  (fwd_src_x_i),
    .fwd_src_y_i  (fwd_src_y_i),
    .fwd_reg_id_i (fwd_reg_id_i),
    .fwd_yumi_o   (fwd_yumi_o),
    .rev_v_o      (rev_v_o),
    .rev_type_o   (rev_type_o),
    .rev_data_o   (rev_data_o),
    .rev_dest_x_o (rev_dest_x_o),
    .rev_dest_y_o (rev_dest_y_o),
    .rev_reg_id_o (rev_reg_id_o),
    .rev_ready_i  (rev_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] d;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [4:0]  id;
  } rsp_t;

  logic [31:0] mm [Els];   // reference memory
  rsp_t        exp_q [$];  // expected responses, acceptance order
  rsp_t        got_log [$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          acc_seen;
  bit          rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted request.
  task automatic model_accept();
    rsp_t        r;
    logic [9:0]  ix;
    logic [31:0] old;
    ix   = fwd_addr_i[9:0];
    r.x  = fwd_src_x_i;
    r.y  = fwd_src_y_i;
    r.id = fwd_reg_id_i;
    r.d  = 32'd0;
    case (fwd_op_i)
      2'd0: begin r.t = 2'd0; r.d = mm[ix]; end
      2'd1: begin
        r.t = 2'd1;
        for (int b = 0; b < 4; b++) if (fwd_mask_i[b]) mm[ix][8*b +: 8] = fwd_data_i[8*b +: 8];
      end
      2'd2: begin
        r.t    = 2'd2;
        old    = mm[ix];
        r.d    = old;
        mm[ix] = old + fwd_data_i;
      end
      default: r.t = 2'd3;
    endcase
    exp_q.push_back(r);
  endtask

  task automatic pop_check();
    rsp_t e, g;
    g = '{t: rev_type_o, d: rev_data_o, x: rev_dest_x_o, y: rev_dest_y_o, id: rev_reg_id_o};
    got_log.push_back(g);
    if (exp_q.size() == 0) begin
      check_eq("rev_unexpected", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("rev_type", 64'(g.t), 64'(e.t));
      check_eq("rev_data", 64'(g.d), 64'(e.d));
      check_eq("rev_dest", 64'({g.x, g.y}), 64'({e.x, e.y}));
      check_eq("rev_reg_id", 64'(g.id), 64'(e.id));
    end
  endtask

  // One clock: sample at negedge, then return 1 time unit after the posedge.
  task automatic step();
    @(negedge clk_i);
    acc_seen = fwd_yumi_o;
    if (fwd_yumi_o) model_accept();
    if (rev_v_o && rev_ready_i) pop_check();
    @(posedge clk_i);
    #1;
    if (rand_ready) rev_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic quiet();
    fwd_v_i      = 1'b0;
    fwd_op_i     = 2'($urandom);
    fwd_addr_i   = 28'($urandom);
    fwd_data_i   = $urandom;
    fwd_mask_i   = 4'($urandom);
    fwd_src_x_i  = 7'($urandom);
    fwd_src_y_i  = 7'($urandom);
    fwd_reg_id_i = 5'($urandom);
  endtask

  task automatic set_req(input logic [1:0] op, input logic [27:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [6:0] x, input logic [6:0] y,
                         input logic [4:0] id);
    fwd_v_i = 1'b1; fwd_op_i = op; fwd_addr_i = a; fwd_data_i = d;
    fwd_mask_i = m; fwd_src_x_i = x; fwd_src_y_i = y; fwd_reg_id_i = id;
  endtask

  // Hold a request until it is consumed; leaves fwd_v_i high for back-to-back use.
  task automatic issue(input logic [1:0] op, input logic [27:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [6:0] x, input logic [6:0] y,
                       input logic [4:0] id);
    int n = 0;
    set_req(op, a, d, m, x, y, id);
    do begin step(); n++; end while (!acc_seen && n < 64);
    if (!acc_seen) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    quiet();
    rand_ready  = 1'b0;
    rev_ready_i = 1'b1;
    while ((exp_q.size() != 0 || rev_v_o) && n < 200) begin step(); n++; end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [31:0] old;
    logic [27:0] a;
    reset_i     = 1'b1;
    rev_ready_i = 1'b1;
    quiet();
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check_eq("idle_yumi", 64'(fwd_yumi_o), 64'd0);
      check_eq("idle_rev_v", 64'(rev_v_o), 64'd0);
      quiet();
      step();
    end

    // Give the model known contents for the indices used below
    for (int i = 0; i < 16; i++) issue(2'd1, 28'(i), $urandom, 4'hF, 7'd1, 7'd1, 5'(i));
    drain();

    // Store then load with latency check
    issue(2'd1, 28'd3, 32'hA5A5A5A5, 4'hF, 7'd2, 7'd5, 5'd6);
    drain();
    got_log.delete();
    issue(2'd0, 28'd3, 32'd0, 4'h0, 7'd2, 7'd5, 5'd7);
    quiet();
    check_eq("ld_lat_t1", 64'(rev_v_o), 64'd0);
    step();
    check_eq("ld_lat_t2", 64'(rev_v_o), 64'd1);
    drain();
    check_eq("ld3_data", 64'(got_log[0].d), 64'hA5A5A5A5);
    check_eq("ld3_type", 64'(got_log[0].t), 64'd0);
    check_eq("ld3_dest", 64'({got_log[0].x, got_log[0].y, got_log[0].id}),
             64'({7'd2, 7'd5, 5'd7}));

    // Masked store
    issue(2'd1, 28'd8, 32'hFFFFFFFF, 4'hF, 7'd0, 7'd0, 5'd0);
    issue(2'd1, 28'd8, 32'h11223344, 4'b0101, 7'd0, 7'd0, 5'd1);
    got_log.delete();
    issue(2'd0, 28'd8, 32'd0, 4'h0, 7'd0, 7'd0, 5'd2);
    drain();
    check_eq("mask_ld", 64'(got_log[got_log.size()-1].d), 64'hFF22FF44);

    // Amoadd, with the following load held off for the writeback cycle
    issue(2'd1, 28'd10, 32'hFFFFFFFE, 4'hF, 7'd3, 7'd3, 5'd0);
    drain();
    got_log.delete();
    issue(2'd2, 28'd10, 32'd5, 4'h0, 7'd3, 7'd3, 5'd1);
    set_req(2'd0, 28'd10, 32'd0, 4'h0, 7'd3, 7'd3, 5'd2);
    step();
    check_eq("amo_wb_yumi", 64'(acc_seen), 64'd0);
    issue(2'd0, 28'd10, 32'd0, 4'h0, 7'd3, 7'd3, 5'd2);
    drain();
    check_eq("amo_rsp", 64'({got_log[0].t, got_log[0].d}), 64'({2'd2, 32'hFFFFFFFE}));
    check_eq("amo_ld", 64'({got_log[1].t, got_log[1].d}), 64'({2'd0, 32'd3}));

    // Backpressure with a two-entry response budget
    got_log.delete();
    rev_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 4) set_req(2'd0, 28'(k), 32'd0, 4'h0, 7'd4, 7'd4, 5'(k));
      else quiet();
      step();
      if (acc_seen) k++;
    end
    check_eq("bp_accepted", 64'(k), 64'd2);
    check_eq("bp_yumi_low", 64'(fwd_yumi_o), 64'd0);
    rev_ready_i = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      set_req(2'd0, 28'(k), 32'd0, 4'h0, 7'd4, 7'd4, 5'(k));
      step();
      if (acc_seen) k++;
    end
    check_eq("bp_all_accepted", 64'(k), 64'd4);
    drain();
    for (int i = 0; i < 4; i++) check_eq("bp_order", 64'(got_log[i].id), 64'(i));

    // Address wrap and illegal op
    got_log.delete();
    issue(2'd0, 28'(Els + 3), 32'd0, 4'h0, 7'd1, 7'd2, 5'd3);
    issue(2'd3, 28'd3, 32'hDEADBEEF, 4'hF, 7'd1, 7'd2, 5'd4);
    issue(2'd0, 28'd3, 32'd0, 4'h0, 7'd1, 7'd2, 5'd5);
    drain();
    check_eq("wrap_ld", 64'(got_log[0].d), 64'hA5A5A5A5);
    check_eq("illegal_rsp", 64'({got_log[1].t, got_log[1].d}), 64'({2'd3, 32'd0}));
    check_eq("illegal_nowrite", 64'(got_log[2].d), 64'hA5A5A5A5);

    // Reset during amo writeback drops the write and the response
    old = mm[12];
    issue(2'd2, 28'd12, 32'h00010001, 4'h0, 7'd5, 7'd5, 5'd9);
    quiet();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    exp_q.delete();
    mm[12] = old;
    check_eq("rst_rev_v", 64'(rev_v_o), 64'd0);
    got_log.delete();
    issue(2'd0, 28'd12, 32'd0, 4'h0, 7'd5, 7'd5, 5'd10);
    drain();
    check_eq("rst_amo_nowrite", 64'(got_log[got_log.size()-1].d), 64'(old));

    // Randomized traffic with random backpressure and idle gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        quiet();
        step();
      end else begin
        a = 28'($urandom);
        a[9:0] = 10'($urandom_range(0, 15));
        issue(2'($urandom), a, $urandom, 4'($urandom), 7'($urandom), 7'($urandom),
              5'($urandom));
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
